// File: rtl/user_io_event_queue.sv
// user_io_event_queue: merges single-cycle pulses from the button and rotary
// parsers into one ordered event stream. Pending events are granted round-robin
// into a show-ahead FIFO that the CPU drains through a valid/pop handshake.
// Optional feature macro: USER_IO_TIMESTAMP_EN (adds per-event cycle timestamps).
module user_io_event_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [4:0]               compass_buttons,
  input  logic                     rotary_push,
  input  logic                     rotary_event,
  input  logic                     rotary_left,
  output logic                     ev_valid,
  output logic [2:0]               ev_code,
  output logic [TS_WIDTH-1:0]      ev_time,
  input  logic                     ev_pop,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef USER_IO_TIMESTAMP_EN
  localparam int unsigned EW = 3 + TS_WIDTH;
`else
  localparam int unsigned EW = 3;
`endif

  logic [7:0]    src;
  logic [7:0]    pend;
  logic [2:0]    rr_ptr;
  logic [2:0]    gnt_idx;
  logic          gnt_found;
  logic [7:0]    gnt_vec;
  logic          push;
  logic          pop_acc;
  logic          full;
  logic          ovf_set;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  // Map parser pulses onto event codes; rotary direction only matters with a detent.
  always_comb begin
    src      = '0;
    src[4:0] = compass_buttons;
    src[5]   = rotary_push;
    src[6]   = rotary_event & ~rotary_left;
    src[7]   = rotary_event &  rotary_left;
  end

  // Round-robin search: first pending source at or after rr_ptr, wrapping 7->0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (!gnt_found && pend[rr_ptr + 3'(k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_ptr + 3'(k);
      end
    end
  end

  // Handshake, grant and overflow decisions for this cycle.
  always_comb begin
    ev_valid = (count != '0);
    pop_acc  = ev_pop & ev_valid;
    full     = (count == (AW+1)'(DEPTH));
    push     = gnt_found & (~full | pop_acc);
    gnt_vec  = push ? (8'd1 << gnt_idx) : '0;
    ovf_set  = |(src & pend & ~gnt_vec);
  end

  // Pending bits, round-robin pointer and the sticky, set-dominant overflow flag.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pend   <= '0;
      rr_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      pend <= src | (pend & ~gnt_vec);
      if (push) rr_ptr <= gnt_idx + 3'd1;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef USER_IO_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] pend_ts [8];

  // Free-running cycle counter; each new pending event latches its arrival time.
  // A pulse arriving while its bit is being granted is a fresh event, so it restamps.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ts <= '0;
      for (int unsigned i = 0; i < 8; i++) pend_ts[i] <= '0;
    end else begin
      ts <= ts + 1'b1;
      for (int unsigned i = 0; i < 8; i++)
        if (src[i] && (!pend[i] || gnt_vec[i])) pend_ts[i] <= ts;
    end
  end

  // Entry layout: {code, timestamp}.
  always_comb begin
    push_data = {gnt_idx, pend_ts[gnt_idx]};
    ev_code   = head[EW-1 -: 3];
    ev_time   = head[TS_WIDTH-1:0];
  end
`else
  // Entry holds the code only; no timestamps in this build.
  always_comb begin
    push_data = gnt_idx;
    ev_code   = head;
    ev_time   = '0;
  end
`endif

  // Show-ahead head read straight from storage.
  always_comb head = mem[rptr];

  // FIFO storage and pointers; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop_acc) rptr <= rptr + 1'b1;
      if (push && !pop_acc)      count <= count + 1'b1;
      else if (!push && pop_acc) count <= count - 1'b1;
    end
  end

  assign ev_count = count;

endmodule

// File: tb/tb_user_io_event_queue.sv
// Directed self-checking bench for user_io_event_queue (DEPTH=8, TS_WIDTH=16).
// Expected values are hand-derived from the round-robin/FIFO behaviour.
module tb_user_io_event_queue;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [4:0]  compass_buttons;
  logic        rotary_push;
  logic        rotary_event;
  logic        rotary_left;
  logic        ev_valid;
  logic [2:0]  ev_code;
  logic [15:0] ev_time;
  logic        ev_pop;
  logic [3:0]  ev_count;
  logic        ovf;
  logic        ovf_clr;

  int unsigned passed = 0;
  int unsigned total  = 0;

  user_io_event_queue #(.DEPTH(8), .TS_WIDTH(16)) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .compass_buttons (compass_buttons),
    .rotary_push     (rotary_push),
    .rotary_event    (rotary_event),
    .rotary_left     (rotary_left),
    .ev_valid        (ev_valid),
    .ev_code         (ev_code),
    .ev_time         (ev_time),
    .ev_pop          (ev_pop),
    .ev_count        (ev_count),
    .ovf             (ovf),
    .ovf_clr         (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    compass_buttons = '0;
    rotary_push     = 1'b0;
    rotary_event    = 1'b0;
    rotary_left     = 1'b0;
  endtask

  // Two-cycle burst covering all 8 sources: cycle A = 0..5 and 7, cycle B = 6.
  // extra4 also re-pulses source 4 in cycle B.
  task automatic burst(input logic extra4);
    compass_buttons = 5'h1f;
    rotary_push     = 1'b1;
    rotary_event    = 1'b1;
    rotary_left     = 1'b1;
    tick();
    compass_buttons = extra4 ? 5'h10 : 5'h00;
    rotary_push     = 1'b0;
    rotary_event    = 1'b1;
    rotary_left     = 1'b0;
    tick();
    clear_inputs();
  endtask

  task automatic pop_expect(input string tag, input logic [2:0] exp);
    chk(tag, 32'(ev_code), 32'(exp));
    ev_pop = 1'b1;
    tick();
    ev_pop = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
  endtask

  logic [15:0] t0;
  logic [2:0]  exp3 [8];
  logic [2:0]  exp4 [8];

  initial begin
    exp3 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
    exp4 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd5, 3'd5};
    rst_b   = 1'b0;
    ev_pop  = 1'b0;
    ovf_clr = 1'b0;
    clear_inputs();
    tick();
    tick();
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_count", 32'(ev_count), 0);
    chk("rst_code",  32'(ev_code),  0);
    chk("rst_ovf",   32'(ovf),      0);
    chk("rst_time",  32'(ev_time),  0);
    rst_b = 1'b1;
    tick();

    // Single pulse on N: pend at edge N, pushed at N+1.
    compass_buttons = 5'b00100;
    tick();
    clear_inputs();
    chk("t1_valid_early", 32'(ev_valid), 0);
    tick();
    chk("t1_valid", 32'(ev_valid), 1);
    chk("t1_code",  32'(ev_code),  2);
    chk("t1_count", 32'(ev_count), 1);
    ev_pop = 1'b1;
    tick();
    ev_pop = 1'b0;
    chk("t1_valid_after_pop", 32'(ev_valid), 0);
    chk("t1_count_after_pop", 32'(ev_count), 0);

    // Full burst from rr_ptr=0, twice: order 0..7 each time.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      burst(1'b0);
      repeat (7) tick();
      chk("t2_count_full", 32'(ev_count), 8);
      tick();
      chk("t2_count_hold", 32'(ev_count), 8);
      for (int i = 0; i < 8; i++) pop_expect("t2_order", 3'(i));
      chk("t2_count_empty", 32'(ev_count), 0);
      chk("t2_ovf", 32'(ovf), 0);
    end

    // Full FIFO, source 3 twice: first waits pending, second coalesces -> ovf.
    burst(1'b0);
    repeat (7) tick();
    chk("t3_count", 32'(ev_count), 8);
    compass_buttons = 5'b01000;
    tick();
    clear_inputs();
    chk("t3_ovf_first", 32'(ovf), 0);
    compass_buttons = 5'b01000;
    tick();
    clear_inputs();
    chk("t3_ovf_second", 32'(ovf), 1);
    chk("t3_count_full", 32'(ev_count), 8);
    pop_expect("t3_head0", 3'd0);
    chk("t3_count_refill", 32'(ev_count), 8);
    chk("t3_ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(ovf), 0);
    for (int i = 0; i < 8; i++) pop_expect("t3_order", exp3[i]);
    chk("t3_empty", 32'(ev_count), 0);

    // Full FIFO, pop held, source 5 streaming: push+pop at full, no ovf.
    burst(1'b0);
    repeat (7) tick();
    chk("t4_count", 32'(ev_count), 8);
    chk("t4_head", 32'(ev_code), 4);
    rotary_push = 1'b1;
    tick();
    chk("t4_count_e0", 32'(ev_count), 8);
    ev_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rotary_push = (i < 3);
      tick();
      chk("t4_count_stream", 32'(ev_count), 8);
      chk("t4_ovf_stream", 32'(ovf), 0);
    end
    ev_pop = 1'b0;
    clear_inputs();
    tick();
    chk("t4_count_after", 32'(ev_count), 8);
    for (int i = 0; i < 8; i++) pop_expect("t4_order", exp4[i]);
    chk("t4_ovf", 32'(ovf), 0);

    // Rotary: left gives 7, right gives 6; direction alone gives nothing.
    rotary_event = 1'b1;
    rotary_left  = 1'b1;
    tick();
    rotary_left  = 1'b0;
    tick();
    rotary_event = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rotary_left = ~rotary_left;
      tick();
    end
    clear_inputs();
    tick();
    chk("t5_count", 32'(ev_count), 2);
    pop_expect("t5_left", 3'd7);
    pop_expect("t5_right", 3'd6);
    chk("t5_empty", 32'(ev_valid), 0);

    // 5 queued, 3 pending, ovf set; async reset clears everything at once.
    burst(1'b1);
    repeat (4) tick();
    chk("t6_count", 32'(ev_count), 5);
    chk("t6_ovf", 32'(ovf), 1);
    #2 rst_b = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(ev_valid), 0);
    chk("t6_rst_count", 32'(ev_count), 0);
    chk("t6_rst_ovf",   32'(ovf),      0);
    tick();
    rst_b = 1'b1;
    repeat (3) tick();
    chk("t6_no_survivor", 32'(ev_count), 0);

`ifdef USER_IO_TIMESTAMP_EN
    // Pulses 100 cycles apart yield a 100-cycle timestamp delta.
    compass_buttons = 5'b00001;
    tick();
    clear_inputs();
    repeat (99) tick();
    compass_buttons = 5'b00010;
    tick();
    clear_inputs();
    tick();
    chk("ts_count", 32'(ev_count), 2);
    t0 = ev_time;
    pop_expect("ts_first", 3'd0);
    chk("ts_delta", 32'(16'(ev_time - t0)), 100);
    pop_expect("ts_second", 3'd1);
`else
    compass_buttons = 5'b00001;
    tick();
    clear_inputs();
    tick();
    t0 = ev_time;
    chk("ts_tied", 32'(t0), 0);
    pop_expect("ts_code", 3'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
